// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - Operation codes: bit 3 = is_store, bit 2 = unsigned load, bits 1:0 = size.
//   - FSM state encoding.
//   - Default data-memory word-address width.
//   - Decode helpers for legality and alignment checks.
package lsu_pkg;

  localparam int LSU_ADDR_W = 10;

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } lsu_state_e;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic addr_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic for the load/store unit.
// Ports:
//   i_size     - access size (byte/half/word)
//   i_unsigned - zero-extend loads instead of sign-extend
//   i_off      - byte offset within the word (addr[1:0])
//   i_rword    - word read from memory
//   i_wdata    - right-aligned store data
//   o_ldata    - extracted and extended load result
//   o_wword    - i_rword with the store lane replaced (read-modify-write word)
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rword,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_ldata,
  output logic [31:0] o_wword
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte  = i_rword[{i_off, 3'b000} +: 8];
    w_half  = i_off[1] ? i_rword[31:16] : i_rword[15:0];
    o_ldata = i_rword;
    o_wword = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        o_ldata = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
        o_wword = i_rword;
        o_wword[{i_off, 3'b000} +: 8] = i_wdata[7:0];
      end
      SZ_HALF: begin
        o_ldata = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
        o_wword = i_rword;
        o_wword[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one CPU request at a time, performs the memory
// access (read, write, or read-modify-write for sub-word stores) and returns
// a single-cycle response.
// Ports:
//   clk, rst_n                - clock, asynchronous active-low reset
//   req_valid/req_ready       - request handshake (ready only when idle)
//   req_op/req_addr/req_wdata - operation, byte address, right-aligned store data
//   resp_valid/rdata/err      - one-cycle completion with load data or error
//   mem_re/mem_we             - memory strobes, held until mem_ack
//   mem_addr/mem_wdata        - word address and full write word
//   mem_rdata/mem_ack         - memory read data and completion
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  lsu_state_e        r_state;
  logic [3:0]        r_op;
  logic [1:0]        r_off;
  logic [31:0]       r_wdata;
  logic              r_mem_re;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [31:0]       r_resp_rdata;

  logic              w_bad_req;
  logic [31:0]       w_ldata;
  logic [31:0]       w_wword;
  logic              w_unused_addr_hi;

  // Address bits above the memory's word range are deliberately dropped.
  assign w_unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign w_bad_req = !op_legal(req_op) || addr_misaligned(req_op[1:0], req_addr[1:0]);

  // Lane logic works on the latched request and the live memory read word,
  // so its outputs are valid in RD at the edge mem_ack is seen.
  lsu_lane_align u_align (
    .i_size     (r_op[1:0]),
    .i_unsigned (r_op[2]),
    .i_off      (r_off),
    .i_rword    (mem_rdata),
    .i_wdata    (r_wdata),
    .o_ldata    (w_ldata),
    .o_wword    (w_wword)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_op         <= '0;
      r_off        <= '0;
      r_wdata      <= '0;
      r_mem_re     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_op       <= req_op;
            r_off      <= req_addr[1:0];
            r_wdata    <= req_wdata;
            r_mem_addr <= req_addr[ADDR_W+1:2];
            if (w_bad_req) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
              r_state      <= ST_RESP;
            end else if (req_op == OP_SW) begin
              // Full-word store needs no read; write straight away.
              r_mem_we    <= 1'b1;
              r_mem_wdata <= req_wdata;
              r_state     <= ST_WR;
            end else begin
              // Loads and sub-word stores both start with a read.
              r_mem_re <= 1'b1;
              r_state  <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (mem_ack) begin
            r_mem_re <= 1'b0;
            if (r_op[3]) begin
              r_mem_we    <= 1'b1;
              r_mem_wdata <= w_wword;
              r_state     <= ST_WR;
            end else begin
              r_resp_valid <= 1'b1;
              r_resp_rdata <= w_ldata;
              r_state      <= ST_RESP;
            end
          end
        end
        ST_WR: begin
          if (mem_ack) begin
            r_mem_we     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= '0;
            r_state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_re     = r_mem_re;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule
